// File: rtl/shift_reg_stream_ctrl.sv
// ---------------------------------------------------------------------------
// shift_reg_stream_ctrl
//
// Elastic Depth-stage delay line between a valid/ready producer and the
// accelerator datapath. Each stage carries a valid bit; a stage loads from
// its upstream neighbour whenever it is empty or everything downstream of it
// can move, so bubbles collapse and items pack toward the output under
// backpressure. Adds occupancy reporting, a drain sequence (stop intake,
// empty the pipe, pulse drain_done_o) and a single-cycle flush.
//
// Optional feature: define SHIFT_REG_STREAM_CTRL_STATS_EN to build the output
// stall counter (stall_cnt_o). Without it stall_cnt_o is tied to zero; the
// port list is the same in both builds.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         asynchronous active-high reset (control state only)
//   in_data_i     input payload            in_valid_i / in_ready_o  handshake
//   out_data_o    last-stage payload       out_valid_o / out_ready_i handshake
//   flush_i       clear all stages (no handshakes in that cycle)
//   drain_i       pulse: stop intake and empty the pipe
//   count_o       number of valid stages (registered)
//   busy_o        controller is not IDLE
//   drain_done_o  one-cycle pulse on the first IDLE cycle after a drain
//   stall_cnt_o   cycles with out_valid_o=1 and out_ready_i=0 (saturating)
// ---------------------------------------------------------------------------
module shift_reg_stream_ctrl #(
  parameter int DataWidth = 8,
  parameter int Depth     = 4,
  parameter int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 flush_i,
  input  logic                 drain_i,
  output logic [CntWidth-1:0]  count_o,
  output logic                 busy_o,
  output logic                 drain_done_o,
  output logic [31:0]          stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [Depth-1:0]      vld_p;
  logic [DataWidth-1:0]  data_p [Depth];
  logic [Depth-1:0]      rdy;
  logic                  in_hs, out_hs;
  logic [CntWidth-1:0]   count_q, count_d;
  logic                  drain_done_q, drain_done_d;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A stage may load when any stage from it to the output is empty, or the
  // output is being accepted. Written as a reduction over the downstream
  // valids rather than a ripple so the vector has no self-dependence.
  for (genvar k = 0; k < Depth; k++) begin : g_rdy
    assign rdy[k] = out_ready_i || !(&vld_p[Depth-1:k]);
  end

  assign in_ready_o   = rdy[0] && (state_q != DRAIN) && !flush_i;
  assign out_valid_o  = vld_p[Depth-1] && !flush_i;
  assign out_data_o   = data_p[Depth-1];
  assign in_hs        = in_valid_i && in_ready_o;
  assign out_hs       = out_valid_o && out_ready_i;
  assign count_o      = count_q;
  assign busy_o       = (state_q != IDLE);
  assign drain_done_o = drain_done_q;

  // ---- stage valids: shift with the ready chain, cleared by flush ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else if (flush_i) begin
      vld_p <= '0;
    end else begin
      if (rdy[0]) vld_p[0] <= in_hs;
      for (int k = 1; k < Depth; k++) begin
        if (rdy[k]) vld_p[k] <= vld_p[k-1];
      end
    end
  end

  // ---- stage data: unreset, follows the same load enables ----
  always_ff @(posedge clk_i) begin
    if (rdy[0]) data_p[0] <= in_data_i;
    for (int k = 1; k < Depth; k++) begin
      if (rdy[k]) data_p[k] <= data_p[k-1];
    end
  end

  // Occupancy: handshakes cannot happen during flush, so clearing here keeps
  // count_q equal to the number of set valid bits.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({in_hs, out_hs})
        2'b10:   count_d = count_q + CntWidth'(1);
        2'b01:   count_d = count_q - CntWidth'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (drain_i)    state_d = DRAIN;
          else if (in_hs) state_d = RUN;
        end
        RUN: begin
          if (drain_i)              state_d = DRAIN;
          else if (count_d == '0)   state_d = IDLE;
        end
        DRAIN: begin
          // Registered pulse lands on the first IDLE cycle.
          if (count_d == '0) begin
            state_d      = IDLE;
            drain_done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      count_q      <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      drain_done_q <= drain_done_d;
    end
  end

`ifdef SHIFT_REG_STREAM_CTRL_STATS_EN
  logic [31:0] stall_cnt_q;

  // Flush masks out_valid_o, so flush cycles never count as stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
    end else if (out_valid_o && !out_ready_i) begin
      stall_cnt_q <= sat_inc32(stall_cnt_q);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_shift_reg_stream_ctrl.sv
module tb_shift_reg_stream_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef SHIFT_REG_STREAM_CTRL_STATS_EN
  localparam logic [31:0] STALL_EXP = 32'd10;
`else
  localparam logic [31:0] STALL_EXP = 32'd0;
`endif

  logic          clk_i       = 1'b0;
  logic          rst_i       = 1'b0;
  logic [DW-1:0] in_data_i   = '0;
  logic          in_valid_i  = 1'b0;
  logic          out_ready_i = 1'b0;
  logic          flush_i     = 1'b0;
  logic          drain_i     = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] out_data_o;
  logic          out_valid_o;
  logic [CW-1:0] count_o;
  logic          busy_o;
  logic          drain_done_o;
  logic [31:0]   stall_cnt_o;

  shift_reg_stream_ctrl #(
    .DataWidth(DW),
    .Depth    (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .flush_i     (flush_i),
    .drain_i     (drain_i),
    .count_o     (count_o),
    .busy_o      (busy_o),
    .drain_done_o(drain_done_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            exp_cyc;
  } sb_t;

  sb_t sb [$];
  sb_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Output monitor: sampled on the falling edge, a handshake seen here
  // completes on the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_unexpected actual=%0h expected=none", out_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", 32'(out_data_o), 32'(mon_e.data));
        if (mon_e.exp_cyc >= 0) chk("out_latency", cyc, mon_e.exp_cyc);
      end
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next();
  endtask

  // Offer one item for one cycle; lat>0 also pins the exit cycle.
  task automatic push(input logic [DW-1:0] d, input logic exp_rdy, input int lat);
    int e;
    in_valid_i = 1'b1;
    in_data_i  = d;
    @(negedge clk_i);
    chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
    if (exp_rdy) begin
      e = (lat > 0) ? cyc + lat : -1;
      sb.push_back('{data: d, exp_cyc: e});
    end
    next();
    in_valid_i = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic async_reset();
    #3 rst_i = 1'b1;
    #2;
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_out_valid", 32'(out_valid_o), 32'd0);
    chk("arst_drain_done", 32'(drain_done_o), 32'd0);
    chk("arst_stall_cnt", stall_cnt_o, 32'd0);
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog_timeout actual=%0d expected<50000ns", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_i = 1'b1;
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_drain_done", 32'(drain_done_o), 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    rst_i = 1'b0;

    // Basic streaming, latency Depth
    out_ready_i = 1'b1;
    push(8'h11, 1'b1, 4);
    push(8'h22, 1'b1, 4);
    push(8'h33, 1'b1, 4);
    @(negedge clk_i);
    chk("t1_count_peak", 32'(count_o), 32'd3);
    chk("t1_busy", 32'(busy_o), 32'd1);
    next();
    idle(3);
    @(negedge clk_i);
    chk("t1_count_end", 32'(count_o), 32'd0);
    chk("t1_busy_end", 32'(busy_o), 32'd0);
    next();

    // Backpressure: four accepts fill the pipe
    out_ready_i = 1'b0;
    push(8'hA0, 1'b1, 0);
    push(8'hA1, 1'b1, 0);
    push(8'hA2, 1'b1, 0);
    push(8'hA3, 1'b1, 0);
    in_valid_i = 1'b1;
    in_data_i  = 8'hA4;
    @(negedge clk_i);
    chk("t2_in_ready_full", 32'(in_ready_o), 32'd0);
    chk("t2_count_full", 32'(count_o), 32'd4);
    next();
    out_ready_i = 1'b1;
    push(8'hA4, 1'b1, 4);
    push(8'hA5, 1'b1, 4);
    idle(6);
    @(negedge clk_i);
    chk("t2_count_end", 32'(count_o), 32'd0);
    chk("t2_busy_end", 32'(busy_o), 32'd0);
    next();

    // Bubble collapse under backpressure
    out_ready_i = 1'b0;
    push(8'h01, 1'b1, 0);
    idle(2);
    push(8'h02, 1'b1, 0);
    idle(4);
    @(negedge clk_i);
    chk("t3_count", 32'(count_o), 32'd2);
    chk("t3_in_ready", 32'(in_ready_o), 32'd1);
    chk("t3_out_valid", 32'(out_valid_o), 32'd1);
    chk("t3_out_data", 32'(out_data_o), 32'h01);
    next();
    out_ready_i = 1'b1;
    idle(3);
    @(negedge clk_i);
    chk("t3_count_end", 32'(count_o), 32'd0);
    next();

    // Drain requested while idle and empty
    drain_i = 1'b1;
    @(negedge clk_i);
    chk("idrain_busy0", 32'(busy_o), 32'd0);
    next();
    drain_i = 1'b0;
    @(negedge clk_i);
    chk("idrain_busy1", 32'(busy_o), 32'd1);
    chk("idrain_done0", 32'(drain_done_o), 32'd0);
    next();
    @(negedge clk_i);
    chk("idrain_done1", 32'(drain_done_o), 32'd1);
    chk("idrain_busy2", 32'(busy_o), 32'd0);
    next();
    @(negedge clk_i);
    chk("idrain_done2", 32'(drain_done_o), 32'd0);
    next();

    // Drain with three items in flight
    push(8'h61, 1'b1, 4);
    push(8'h62, 1'b1, 4);
    push(8'h63, 1'b1, 4);
    drain_i = 1'b1;
    @(negedge clk_i);
    chk("t4_done_req", 32'(drain_done_o), 32'd0);
    next();
    drain_i    = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = 8'h64;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t4_in_ready", 32'(in_ready_o), 32'd0);
      chk("t4_busy", 32'(busy_o), 32'd1);
      chk("t4_done_early", 32'(drain_done_o), 32'd0);
      next();
    end
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t4_done", 32'(drain_done_o), 32'd1);
    chk("t4_busy_end", 32'(busy_o), 32'd0);
    chk("t4_count_end", 32'(count_o), 32'd0);
    next();
    @(negedge clk_i);
    chk("t4_done_once", 32'(drain_done_o), 32'd0);
    next();

    // Flush aborts a drain with two items held
    out_ready_i = 1'b0;
    push(8'h71, 1'b1, 0);
    push(8'h72, 1'b1, 0);
    drain_i = 1'b1;
    @(negedge clk_i);
    chk("t5_count", 32'(count_o), 32'd2);
    next();
    drain_i     = 1'b0;
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    in_data_i   = 8'h73;
    @(negedge clk_i);
    chk("t5_flush_out_valid", 32'(out_valid_o), 32'd0);
    chk("t5_flush_in_ready", 32'(in_ready_o), 32'd0);
    chk("t5_flush_busy", 32'(busy_o), 32'd1);
    sb.delete();
    next();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t5_count_after", 32'(count_o), 32'd0);
    chk("t5_busy_after", 32'(busy_o), 32'd0);
    chk("t5_out_valid_after", 32'(out_valid_o), 32'd0);
    chk("t5_done_after", 32'(drain_done_o), 32'd0);
    next();
    @(negedge clk_i);
    chk("t5_done_after2", 32'(drain_done_o), 32'd0);
    next();
    push(8'h5A, 1'b1, 4);
    idle(4);
    @(negedge clk_i);
    chk("t5_count_end", 32'(count_o), 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    next();

    // Stall statistic: reset first so earlier stalls do not count
    async_reset();
    out_ready_i = 1'b0;
    push(8'h3C, 1'b1, 0);
    idle(13);
    flush_i = 1'b1;
    @(negedge clk_i);
    chk("t6_stall_cnt", stall_cnt_o, STALL_EXP);
    sb.delete();
    next();
    flush_i = 1'b0;
    @(negedge clk_i);
    chk("t6_stall_after_flush", stall_cnt_o, STALL_EXP);
    chk("t6_count_after_flush", 32'(count_o), 32'd0);
    next();

    // Asynchronous reset with an item in flight
    push(8'h77, 1'b1, 0);
    idle(2);
    async_reset();
    @(negedge clk_i);
    chk("t7_out_valid", 32'(out_valid_o), 32'd0);
    chk("t7_count", 32'(count_o), 32'd0);
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
